// File: rtl/irrigation_cycle_scheduler.sv
// irrigation_cycle_scheduler: one irrigation cycle (start checks, mode latch, BCD mm:ss countdown,
// tank refill pause, rest period, sensor-fault handling). Define IRRIGATION_ABORT_EN for wet-soil abort.
module irrigation_cycle_scheduler #(
  parameter int SPRINKLER_TIME_S = 600,
  parameter int DRIPPER_TIME_S   = 1200,
  parameter int REST_TIME_S      = 300
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       water_supply_valvule,
  output logic       alarm,
  output logic [3:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [3:0] seconds_d,
  output logic [3:0] seconds_u,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IRRIGATE = 3'd1,
    ST_REFILL   = 3'd2,
    ST_REST     = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  function automatic logic [15:0] to_bcd(input int secs);
    int mins;
    int secs_rem;
    mins     = secs / 60;
    secs_rem = secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs_rem / 10), 4'(secs_rem % 10)};
  endfunction

  // Digit-wise borrow chain; 00:00 holds.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] md, mu, sd, su;
    {md, mu, sd, su} = t;
    if (t == 16'h0000) begin
      su = 4'd0;
    end else if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (sd != 4'd0) begin
        sd = sd - 4'd1;
      end else begin
        sd = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          md = md - 4'd1;
        end
      end
    end
    return {md, mu, sd, su};
  endfunction

  localparam logic [15:0] SPR_BCD  = to_bcd(SPRINKLER_TIME_S);
  localparam logic [15:0] DRP_BCD  = to_bcd(DRIPPER_TIME_S);
  localparam logic [15:0] REST_BCD = to_bcd(REST_TIME_S);

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  clr_cnt_q, clr_cnt_d;
  logic        supply_q, supply_d;
  logic        pump_q, pump_d;
  logic        drip_q, drip_d;
  logic        alarm_q, alarm_d;

  logic        conflict_s, hyst_s, start_s, mode_sel_s, dec_zero_s;
  logic [15:0] dec_s;

  assign conflict_s = (mid_water_level & ~low_water_level) | (high_water_level & ~mid_water_level);
  assign hyst_s     = ~mid_water_level ? 1'b1 : (high_water_level ? 1'b0 : supply_q);
  assign start_s    = ~earth_humidity & low_water_level;
  assign mode_sel_s = ~air_humidity & ~low_temperature & mid_water_level;
  assign dec_s      = bcd_dec(timer_q);
  assign dec_zero_s = (dec_s == 16'h0000);

  // Next-state, timer and supply-valve decision from this edge's samples.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    timer_d   = timer_q;
    clr_cnt_d = clr_cnt_q;
    supply_d  = supply_q;
    if (conflict_s) begin
      state_d   = ST_ERROR;
      timer_d   = 16'h0000;
      clr_cnt_d = 2'd0;
      supply_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_d  = ST_IRRIGATE;
            mode_d   = mode_sel_s;
            timer_d  = mode_sel_s ? SPR_BCD : DRP_BCD;
            supply_d = 1'b0;
          end else begin
            supply_d = hyst_s;
          end
        end
        ST_IRRIGATE: begin
          if (!low_water_level) begin
            state_d  = ST_REFILL;
            supply_d = 1'b1;
          end
`ifdef IRRIGATION_ABORT_EN
          else if (tick && earth_humidity) begin
            state_d  = ST_REST;
            timer_d  = REST_BCD;
            supply_d = 1'b0;
          end
`endif
          else if (tick) begin
            if (dec_zero_s) begin
              state_d  = ST_REST;
              timer_d  = REST_BCD;
              supply_d = hyst_s;
            end else begin
              timer_d = dec_s;
            end
          end else begin
            supply_d = 1'b0;
          end
        end
        ST_REFILL: begin
`ifdef IRRIGATION_ABORT_EN
          if (tick && earth_humidity) begin
            state_d  = ST_REST;
            timer_d  = REST_BCD;
            supply_d = 1'b0;
          end else
`endif
          if (mid_water_level) begin
            state_d  = ST_IRRIGATE;
            supply_d = 1'b0;
          end else begin
            supply_d = 1'b1;
          end
        end
        ST_REST: begin
          supply_d = hyst_s;
          if (tick) begin
            timer_d = dec_s;
            if (dec_zero_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_REST;
            end
          end else begin
            timer_d = timer_q;
          end
        end
        ST_ERROR: begin
          supply_d = 1'b0;
          timer_d  = 16'h0000;
          if (tick) begin
            if (clr_cnt_q == 2'd1) begin
              state_d   = ST_IDLE;
              clr_cnt_d = 2'd0;
            end else begin
              clr_cnt_d = clr_cnt_q + 2'd1;
            end
          end else begin
            clr_cnt_d = clr_cnt_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          timer_d   = 16'h0000;
          clr_cnt_d = 2'd0;
          supply_d  = 1'b0;
        end
      endcase
    end
  end

  assign pump_d  = (state_d == ST_IRRIGATE) & mode_d;
  assign drip_d  = (state_d == ST_IRRIGATE) & ~mode_d;
  assign alarm_d = (state_d == ST_ERROR);

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      timer_q   <= 16'h0000;
      clr_cnt_q <= 2'd0;
      supply_q  <= 1'b0;
      pump_q    <= 1'b0;
      drip_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      timer_q   <= timer_d;
      clr_cnt_q <= clr_cnt_d;
      supply_q  <= supply_d;
      pump_q    <= pump_d;
      drip_q    <= drip_d;
      alarm_q   <= alarm_d;
    end
  end

  assign splinker_bomb        = pump_q;
  assign dripper_valvule      = drip_q;
  assign water_supply_valvule = supply_q;
  assign alarm                = alarm_q;
  assign {minutes_d, minutes_u, seconds_d, seconds_u} = timer_q;
  assign phase                = state_q;

endmodule

// File: tb/tb_irrigation_cycle_scheduler.sv
// Bench for irrigation_cycle_scheduler: directed sequences, a vector table and random stimulus
// checked against a seconds-based reference model.
module tb_irrigation_cycle_scheduler;

  localparam int SPR  = 3;
  localparam int DRP  = 61;
  localparam int REST = 300;
  localparam int DRP2 = 756;

  logic clock, reset_n, tick;
  logic low_w, mid_w, high_w, earth, air, cold;

  logic       pump1, drip1, sup1, alarm1;
  logic [3:0] md1, mu1, sd1, su1;
  logic [2:0] ph1;
  logic       pump2, drip2, sup2, alarm2;
  logic [3:0] md2, mu2, sd2, su2;
  logic [2:0] ph2;

  logic [15:0] tmr1, tmr2;
  logic [22:0] obs1, obs2;
  assign tmr1 = {md1, mu1, sd1, su1};
  assign tmr2 = {md2, mu2, sd2, su2};
  assign obs1 = {ph1, tmr1, pump1, drip1, sup1, alarm1};
  assign obs2 = {ph2, tmr2, pump2, drip2, sup2, alarm2};

  irrigation_cycle_scheduler #(.SPRINKLER_TIME_S(SPR), .DRIPPER_TIME_S(DRP), .REST_TIME_S(REST)) u_dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .low_water_level(low_w), .mid_water_level(mid_w), .high_water_level(high_w),
    .earth_humidity(earth), .air_humidity(air), .low_temperature(cold),
    .splinker_bomb(pump1), .dripper_valvule(drip1), .water_supply_valvule(sup1), .alarm(alarm1),
    .minutes_d(md1), .minutes_u(mu1), .seconds_d(sd1), .seconds_u(su1), .phase(ph1));

  irrigation_cycle_scheduler #(.SPRINKLER_TIME_S(SPR), .DRIPPER_TIME_S(DRP2), .REST_TIME_S(REST)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .low_water_level(low_w), .mid_water_level(mid_w), .high_water_level(high_w),
    .earth_humidity(earth), .air_humidity(air), .low_temperature(cold),
    .splinker_bomb(pump2), .dripper_valvule(drip2), .water_supply_valvule(sup2), .alarm(alarm2),
    .minutes_d(md2), .minutes_u(mu2), .seconds_d(sd2), .seconds_u(su2), .phase(ph2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase code, remaining seconds as a plain integer.
  int   m_ph, m_rem, m_cnt;
  logic m_spr, m_sup;

  function automatic logic [15:0] sec_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic hyst(input logic m, input logic h, input logic cur);
    return !m ? 1'b1 : (h ? 1'b0 : cur);
  endfunction

  function automatic logic [22:0] model_vec();
    return {3'(m_ph), sec_bcd(m_rem), (m_ph == 1) && m_spr, (m_ph == 1) && !m_spr, m_sup, m_ph == 4};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = 0; m_cnt = 0; m_spr = 1'b0; m_sup = 1'b0;
  endtask

  task automatic model_step(input logic [6:0] v);
    logic t, l, m, h, e, a, c;
    {t, l, m, h, e, a, c} = v;
    if ((m && !l) || (h && !m)) begin
      m_ph = 4; m_rem = 0; m_cnt = 0; m_sup = 1'b0;
    end else begin
      case (m_ph)
        0: if (!e && l) begin
             m_spr = !a && !c && m; m_rem = m_spr ? SPR : DRP; m_ph = 1; m_sup = 1'b0;
           end else m_sup = hyst(m, h, m_sup);
        1: if (!l) begin m_ph = 2; m_sup = 1'b1; end
`ifdef IRRIGATION_ABORT_EN
           else if (t && e) begin m_ph = 3; m_rem = REST; m_sup = 1'b0; end
`endif
           else if (t) begin
             m_rem = m_rem - 1;
             if (m_rem == 0) begin m_ph = 3; m_rem = REST; m_sup = hyst(m, h, m_sup); end
           end
        2: begin
`ifdef IRRIGATION_ABORT_EN
             if (t && e) begin m_ph = 3; m_rem = REST; m_sup = 1'b0; end else
`endif
             if (m) begin m_ph = 1; m_sup = 1'b0; end
           end
        3: begin
             m_sup = hyst(m, h, m_sup);
             if (t) begin m_rem = m_rem - 1; if (m_rem == 0) m_ph = 0; end
           end
        4: if (t) begin m_cnt = m_cnt + 1; if (m_cnt == 2) begin m_ph = 0; m_cnt = 0; end end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive {tick,low,mid,high,earth,air,cold}, advance one clock, compare with the model.
  task automatic apply(input logic [6:0] v);
    {tick, low_w, mid_w, high_w, earth, air, cold} = v;
    model_step(v);
    @(posedge clock);
    #1;
    chk("model", 32'(obs1), 32'(model_vec()));
  endtask

  typedef struct {
    logic [6:0]  in;
    logic [2:0]  ph;
    logic [15:0] tmr;
    logic        pump, drip, sup, alm;
  } vec_t;

  vec_t tbl[13];
  logic [1:0] lvl;
  logic       e_r;

  initial begin
    // Fault/clear-counter sequence, then IDLE supply-valve hysteresis.
    tbl[0]  = '{7'b0010110, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{7'b1110110, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{7'b0010110, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{7'b1110110, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{7'b0110110, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{7'b1110110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{7'b0100110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{7'b0110110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{7'b0111110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{7'b0110110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{7'b1110110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{7'b0000010, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{7'b1000110, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

    {tick, low_w, mid_w, high_w, earth, air, cold} = 7'b0;
    model_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_state", 32'(obs1), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Sprinkler cycle of 3 s, then the 5 min rest.
    apply(7'b0110000);
    chk("spr_start", {ph1, tmr1, pump1, drip1}, {3'd1, 16'h0003, 1'b1, 1'b0});
    apply(7'b1110000);
    chk("spr_t1", 32'(tmr1), 32'h0002);
    apply(7'b1110000);
    chk("spr_t2", 32'(tmr1), 32'h0001);
    apply(7'b1110000);
    chk("spr_end", {ph1, tmr1, pump1}, {3'd3, 16'h0500, 1'b0});
    apply(7'b0110000);
    chk("rest_ignores_dry", {ph1, tmr1}, {3'd3, 16'h0500});
    for (int i = 0; i < REST - 1; i++) apply(7'b1110100);
    chk("rest_last", {ph1, tmr1}, {3'd3, 16'h0001});
    apply(7'b1110100);
    chk("rest_done", {ph1, tmr1}, {3'd0, 16'h0000});

    // Dripper cycle 01:01 with borrow chain, then refill pause at 00:07.
    apply(7'b0110010);
    chk("drp_start", {ph1, tmr1, pump1, drip1}, {3'd1, 16'h0101, 1'b0, 1'b1});
    apply(7'b1110110);
    apply(7'b1110110);
    chk("drp_borrow", 32'(tmr1), 32'h0059);
    for (int i = 0; i < 52; i++) apply(7'b1110110);
    chk("drp_at7", 32'(tmr1), 32'h0007);
    apply(7'b0000110);
    chk("refill_enter", {ph1, tmr1, sup1, drip1}, {3'd2, 16'h0007, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      apply(7'b1000110);
      chk("refill_frozen", {ph1, tmr1, sup1}, {3'd2, 16'h0007, 1'b1});
    end
    apply(7'b0110110);
    chk("refill_resume", {ph1, tmr1, sup1, drip1}, {3'd1, 16'h0007, 1'b0, 1'b1});

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].in);
      chk($sformatf("tbl%0d", i), {ph1, tmr1, pump1, drip1, sup1, alarm1},
          {tbl[i].ph, tbl[i].tmr, tbl[i].pump, tbl[i].drip, tbl[i].sup, tbl[i].alm});
    end

    // Asynchronous reset mid-countdown at 12:34 on the second instance.
    apply(7'b0110010);
    chk("dut2_load", 32'(tmr2), 32'h1236);
    apply(7'b1110110);
    apply(7'b1110110);
    chk("dut2_at_1234", {ph2, tmr2, drip2}, {3'd1, 16'h1234, 1'b1});
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_dut1", 32'(obs1), 32'h0);
    chk("async_rst_dut2", 32'(obs2), 32'h0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    apply(7'b0110110);
    chk("post_rst_idle", {ph2, tmr2}, {3'd0, 16'h0000});

    // Random stimulus against the model.
    lvl = 2'd2;
    e_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] lmh;
      if ($urandom_range(0, 7) == 0) lvl = 2'($urandom_range(0, 3));
      lmh = {lvl >= 2'd1, lvl >= 2'd2, lvl == 2'd3};
      if ($urandom_range(0, 31) == 0) lmh = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) e_r = ~e_r;
      apply({1'($urandom_range(0, 1)), lmh, e_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irrigation_cycle_scheduler.md
Name: irrigation_cycle_scheduler

Overview:
Sequences one complete irrigation cycle for the greenhouse controller. It checks the prerequisites, latches the irrigation mode (sprinkler or dripper) and runs a BCD mm:ss countdown. It pauses the cycle to refill the tank, enforces a rest period between cycles, and handles sensor faults. It drives the sprinkler pump, dripper valve, supply valve, alarm LED and the four display digits, replacing the free-running countdown chain and the loose valve gating.

Parameters:
SPRINKLER_TIME_S, 600, sprinkler cycle length in seconds; legal range 1..2399.
DRIPPER_TIME_S, 1200, dripper cycle length in seconds; legal range 1..2399.
REST_TIME_S, 300, rest between cycles in seconds; legal range 1..2399.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-clock-wide 1 Hz enable
low_water_level  input  1  tank at or above low sensor
mid_water_level  input  1  tank at or above mid sensor
high_water_level  input  1  tank at or above high sensor
earth_humidity  input  1  1 = soil wet, 0 = soil dry (needs water)
air_humidity  input  1  1 = humid air
low_temperature  input  1  1 = cold
splinker_bomb  output  1  sprinkler pump on
dripper_valvule  output  1  dripper valve open
water_supply_valvule  output  1  tank supply valve open
alarm  output  1  sensor fault indication
minutes_d  output  4  BCD minutes tens, 0..3
minutes_u  output  4  BCD minutes units, 0..9
seconds_d  output  4  BCD seconds tens, 0..5
seconds_u  output  4  BCD seconds units, 0..9
phase  output  3  state code: IDLE=0, IRRIGATE=1, REFILL=2, REST=3, ERROR=4

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: all outputs 0, phase=IDLE, timer 00:00, sprinkler-mode latch 0, error-clear counter 0. Reset mid-cycle aborts immediately with no resume.
- Registers: every output is registered. Every decision uses the input values sampled at the same clock edge, and the outputs reflect the decision one clock later.
- Sensor fault: conflict = (mid & ~low) | (high & ~mid). Priority is conflict > low-water > tick.
- Any state, conflict=1: go to ERROR.
  - Valves and pump 0, alarm=1, timer=00:00.
  - Every tick with conflict=0 increments the clear counter. Any conflict=1 zeroes it.
  - When the counter reaches 2, go to IDLE.
- IDLE:
  - Supply valve uses hysteresis: it goes to 1 when mid=0 and to 0 when high=1; otherwise it holds its value.
  - Start condition: earth_humidity=0 and low=1 and no conflict. On start, latch the mode, load the timer and go to IRRIGATE; no tick is needed.
  - Mode: sprinkler when air_humidity=0, low_temperature=0 and mid=1; otherwise dripper.
  - Timer load: SPRINKLER_TIME_S or DRIPPER_TIME_S, converted to BCD at elaboration.
- IRRIGATE:
  - Exactly one of splinker_bomb or dripper_valvule is 1, per the latched mode. The mode does not change mid-cycle.
  - Supply valve is 0.
  - low=0: go to REFILL with the timer frozen.
  - Otherwise, on each tick the timer decrements. When the decremented value is 00:00, load REST_TIME_S and go to REST on that same edge. The cycle therefore lasts exactly N ticks.
- REFILL: pump and dripper 0, supply valve 1, timer frozen. When mid=1, return to IRRIGATE and resume from the frozen value.
- REST:
  - Supply valve uses the IDLE hysteresis.
  - Timer decrements on each tick. When it reaches 00:00, go to IDLE.
  - A dry-soil request is ignored until then.
- BCD decrement, when the timer is nonzero:
  - seconds_u 0 goes to 9 with a borrow; seconds_d 0 goes to 5 with a borrow; minutes_u 0 goes to 9 with a borrow; minutes_d decrements.
  - Decrementing at 00:00 never occurs; the timer holds 00:00.
- tick on the same cycle as a state entry: it is not applied in the new state.

Optional Feature:
IRRIGATION_ABORT_EN:
- Defined: in IRRIGATE or REFILL, earth_humidity=1 sampled on a tick aborts the cycle. Pump and valves go to 0, REST_TIME_S is loaded and the block enters REST.
- Undefined: soil humidity is ignored after start, and the cycle always runs its full time.

Test Plan:
- Dry soil, low=mid=1, high=0, air_humidity=0, low_temperature=0, SPRINKLER_TIME_S=3 -> splinker_bomb=1, timer 00:03 then 00:02, 00:01; on the 3rd tick phase=REST, timer 05:00, pump 0.
- Dry soil, air_humidity=1, DRIPPER_TIME_S=61 -> dripper_valvule=1 and timer 01:01; after 2 ticks timer 00:59 (borrow chain checked).
- In IRRIGATE at 00:07, drop low and mid -> phase=REFILL, supply valve 1, timer stays 00:07 across 5 ticks; raise low and mid -> IRRIGATE resumes at 00:07.
- Apply mid=1, low=0 during IRRIGATE -> ERROR with alarm=1 and all valves 0; fix sensors -> IDLE after exactly 2 ticks; reassert the fault after 1 tick -> still ERROR.
- In IDLE with high=0, mid=0 -> supply valve 1; raise mid -> stays 1; raise high -> 0.
- Assert reset_n low mid-countdown at 12:34 -> all outputs 0 immediately with no clock edge; release -> phase=IDLE, timer 00:00.
